// File: rtl/axis_in_buffer_pkg.sv
// Shared training constants plus the input buffer's state codes and helpers.
`ifndef CONSTS_TRAIN_VH
`define CONSTS_TRAIN_VH
`define CHAR_LEN   8
`define N          4
`define BATCH_SIZE 3
`endif

package axis_in_buffer_pkg;

    localparam int CHAR_LEN_P   = `CHAR_LEN;
    localparam int N_P          = `N;
    localparam int BATCH_SIZE_P = `BATCH_SIZE;
    localparam int BEATS_P      = BATCH_SIZE_P * N_P;

    // Counter width that never collapses to zero bits.
    function automatic int clog2_min1(input int v);
        return ($clog2(v) < 1) ? 1 : $clog2(v);
    endfunction

    localparam int WR_W = clog2_min1(BEATS_P);
    localparam int RD_W = clog2_min1(BATCH_SIZE_P);

    typedef enum logic [1:0] {
        IB_RECV  = 2'd0,
        IB_DRAIN = 2'd1,
        IB_OUT   = 2'd2
    } ib_state_e;

endpackage

// File: rtl/axis_in_buffer.sv
// Collects one batch of AXI-Stream characters, checks its length against
// TLAST, then presents it one sample (N characters) at a time downstream.
module axis_in_buffer
    import axis_in_buffer_pkg::*;
(
    input  logic                          ACLK,
    input  logic                          ARESET,
    input  logic                          clear,
    input  logic [`CHAR_LEN-1:0]          S_AXIS_TDATA,
    input  logic                          S_AXIS_TLAST,
    input  logic                          S_AXIS_TVALID,
    output logic                          S_AXIS_TREADY,
    output logic [`N*`CHAR_LEN-1:0]       q_data,
    output logic                          q_valid,
    input  logic                          q_ready,
    output logic                          q_last,
    output logic                          len_err
);

    localparam logic [WR_W-1:0] LAST_BEAT = WR_W'(BEATS_P - 1);
    localparam logic [RD_W-1:0] LAST_SMPL = RD_W'(BATCH_SIZE_P - 1);

    ib_state_e         state_q, state_d;
    logic [WR_W-1:0]   wr_cnt_q, wr_cnt_d;
    logic [RD_W-1:0]   rd_idx_q, rd_idx_d;
    logic              len_err_q, len_err_d;
    logic              mem_we;
    logic [WR_W-1:0]   rd_base;

    logic [CHAR_LEN_P-1:0] mem_q [BEATS_P];

    // Next-state, counter updates and handshake outputs.
    always_comb begin
        state_d       = state_q;
        wr_cnt_d      = wr_cnt_q;
        rd_idx_d      = rd_idx_q;
        len_err_d     = len_err_q;
        mem_we        = 1'b0;
        S_AXIS_TREADY = 1'b1;
        q_valid       = 1'b0;
        q_last        = 1'b0;
        case (state_q)
            IB_RECV: begin
                if (S_AXIS_TVALID) begin
                    if (S_AXIS_TLAST) begin
                        if (wr_cnt_q == LAST_BEAT) begin
                            mem_we   = 1'b1;
                            rd_idx_d = '0;
                            state_d  = IB_OUT;
                        end else begin
                            // Short batch: drop what was collected.
                            len_err_d = 1'b1;
                            wr_cnt_d  = '0;
                        end
                    end else begin
                        mem_we = 1'b1;
                        if (wr_cnt_q == LAST_BEAT) state_d = IB_DRAIN;
                        else                       wr_cnt_d = wr_cnt_q + 1'b1;
                    end
                end
            end
            IB_DRAIN: begin
                // Overlong batch: swallow beats until its TLAST.
                if (S_AXIS_TVALID && S_AXIS_TLAST) begin
                    len_err_d = 1'b1;
                    wr_cnt_d  = '0;
                    state_d   = IB_RECV;
                end
            end
            IB_OUT: begin
                S_AXIS_TREADY = 1'b0;
                q_valid       = 1'b1;
                q_last        = (rd_idx_q == LAST_SMPL);
                if (q_ready) begin
                    if (rd_idx_q == LAST_SMPL) begin
                        rd_idx_d = '0;
                        wr_cnt_d = '0;
                        state_d  = IB_RECV;
                    end else begin
                        rd_idx_d = rd_idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IB_RECV;
        endcase
    end

    // State and counters; reset and clear both flush, ahead of any handshake.
    always_ff @(posedge ACLK) begin
        if (ARESET || clear) begin
            state_q   <= IB_RECV;
            wr_cnt_q  <= '0;
            rd_idx_q  <= '0;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_idx_q  <= rd_idx_d;
            len_err_q <= len_err_d;
        end
    end

    // Character store; deliberately not reset, written only while receiving.
    always_ff @(posedge ACLK) begin
        if (mem_we) mem_q[wr_cnt_q] <= S_AXIS_TDATA;
    end

    assign rd_base = WR_W'(rd_idx_q) * WR_W'(N_P);

    for (genvar j = 0; j < N_P; j++) begin : g_char
        assign q_data[j*CHAR_LEN_P +: CHAR_LEN_P] = mem_q[rd_base + WR_W'(j)];
    end

    assign len_err = len_err_q;

endmodule

// File: tb/tb_axis_in_buffer.sv
// Directed bench for axis_in_buffer: nominal, stall, short/long batch,
// clear mid-output and reset mid-receive.
module tb_axis_in_buffer;
    import axis_in_buffer_pkg::*;

    localparam int DW = N_P * CHAR_LEN_P;

    logic          ACLK = 1'b0;
    logic          ARESET, clear;
    logic [CHAR_LEN_P-1:0] S_AXIS_TDATA;
    logic          S_AXIS_TLAST, S_AXIS_TVALID, S_AXIS_TREADY;
    logic [DW-1:0] q_data;
    logic          q_valid, q_ready, q_last, len_err;

    int checks = 0;
    int errors = 0;

    axis_in_buffer dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .clear         (clear),
        .S_AXIS_TDATA  (S_AXIS_TDATA),
        .S_AXIS_TLAST  (S_AXIS_TLAST),
        .S_AXIS_TVALID (S_AXIS_TVALID),
        .S_AXIS_TREADY (S_AXIS_TREADY),
        .q_data        (q_data),
        .q_valid       (q_valid),
        .q_ready       (q_ready),
        .q_last        (q_last),
        .len_err       (len_err)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] smpl(input int s);
        logic [DW-1:0] v = '0;
        for (int j = 0; j < N_P; j++) v[j*CHAR_LEN_P +: CHAR_LEN_P] = CHAR_LEN_P'(s*N_P + j);
        return v;
    endfunction

    // Stream nbeats with data=k, TLAST on the final beat; ends at a negedge.
    task automatic send(input int nbeats);
        for (int k = 0; k < nbeats; k++) begin
            @(negedge ACLK);
            chk("rx_tready", 32'(S_AXIS_TREADY), 32'd1);
            chk("rx_qvalid", 32'(q_valid), 32'd0);
            S_AXIS_TVALID = 1'b1;
            S_AXIS_TDATA  = CHAR_LEN_P'(k);
            S_AXIS_TLAST  = (k == nbeats - 1);
        end
        @(negedge ACLK);
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TLAST  = 1'b0;
    endtask

    // Consume all samples with 'stall' idle cycles before each handshake.
    task automatic recv(input int stall);
        for (int s = 0; s < BATCH_SIZE_P; s++) begin
            for (int c = 0; c < stall; c++) begin
                q_ready = 1'b0;
                chk("stall_valid", 32'(q_valid), 32'd1);
                chk("stall_data", q_data, smpl(s));
                chk("stall_tready", 32'(S_AXIS_TREADY), 32'd0);
                @(negedge ACLK);
            end
            chk("out_valid", 32'(q_valid), 32'd1);
            chk("out_data", q_data, smpl(s));
            chk("out_last", 32'(q_last), 32'(s == BATCH_SIZE_P - 1));
            chk("out_tready", 32'(S_AXIS_TREADY), 32'd0);
            q_ready = 1'b1;
            @(negedge ACLK);
        end
        q_ready = 1'b0;
        chk("post_tready", 32'(S_AXIS_TREADY), 32'd1);
        chk("post_valid", 32'(q_valid), 32'd0);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge ACLK);
        clear = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ARESET = 1'b1; clear = 1'b0; q_ready = 1'b0;
        S_AXIS_TVALID = 1'b0; S_AXIS_TLAST = 1'b0; S_AXIS_TDATA = '0;
        repeat (3) @(negedge ACLK);
        chk("rst_tready", 32'(S_AXIS_TREADY), 32'd1);
        chk("rst_valid", 32'(q_valid), 32'd0);
        chk("rst_last", 32'(q_last), 32'd0);
        chk("rst_lenerr", 32'(len_err), 32'd0);
        ARESET = 1'b0;

        // Nominal batch; q_valid must be up one cycle after TLAST.
        send(BEATS_P);
        recv(0);
        chk("nom_lenerr", 32'(len_err), 32'd0);

        // Downstream backpressure.
        send(BEATS_P);
        recv(5);

        // Short batch, then a good batch with the sticky error still set.
        send(4);
        chk("short_lenerr", 32'(len_err), 32'd1);
        chk("short_valid", 32'(q_valid), 32'd0);
        chk("short_tready", 32'(S_AXIS_TREADY), 32'd1);
        send(BEATS_P);
        recv(0);
        chk("short_sticky", 32'(len_err), 32'd1);
        do_clear();
        chk("clr_lenerr", 32'(len_err), 32'd0);

        // Long batch; stays idle, error set, back in receive.
        send(BEATS_P + 2);
        chk("long_lenerr", 32'(len_err), 32'd1);
        chk("long_valid", 32'(q_valid), 32'd0);
        chk("long_tready", 32'(S_AXIS_TREADY), 32'd1);

        // Clear mid-output after sample 0, colliding with a handshake.
        send(BEATS_P);
        chk("mid_s0", q_data, smpl(0));
        q_ready = 1'b1;
        @(negedge ACLK);
        chk("mid_s1", q_data, smpl(1));
        clear = 1'b1;
        @(negedge ACLK);
        clear = 1'b0; q_ready = 1'b0;
        chk("mclr_valid", 32'(q_valid), 32'd0);
        chk("mclr_tready", 32'(S_AXIS_TREADY), 32'd1);
        chk("mclr_lenerr", 32'(len_err), 32'd0);
        send(BEATS_P);
        recv(1);

        // Reset on beat 5 of a batch; that beat must be dropped.
        for (int k = 0; k < 5; k++) begin
            @(negedge ACLK);
            S_AXIS_TVALID = 1'b1; S_AXIS_TDATA = CHAR_LEN_P'(k + 8'h40); S_AXIS_TLAST = 1'b0;
        end
        @(negedge ACLK);
        S_AXIS_TDATA = CHAR_LEN_P'(8'h45);
        ARESET = 1'b1;
        @(negedge ACLK);
        ARESET = 1'b0; S_AXIS_TVALID = 1'b0;
        chk("arst_tready", 32'(S_AXIS_TREADY), 32'd1);
        chk("arst_valid", 32'(q_valid), 32'd0);
        send(BEATS_P);
        recv(0);
        chk("arst_lenerr", 32'(len_err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_in_buffer.md
AXIS_IN_BUFFER -- requirements
Module: axis_in_buffer

Interface
REQ-001 Macro `CHAR_LEN`, from consts_train.vh: bits per character.
REQ-002 Macro `N`, from consts_train.vh: characters per sample.
REQ-003 Macro `BATCH_SIZE`, from consts_train.vh: samples per batch; one batch = BATCH_SIZE*N beats.
REQ-004 Port ACLK, input, 1: single clock; all logic is rising-edge.
REQ-005 Port ARESET, input, 1: reset, synchronous, active-high.
REQ-006 Port clear, input, 1: synchronous flush from the main controller.
REQ-007 Port S_AXIS_TDATA, input, CHAR_LEN: one character per beat.
REQ-008 Port S_AXIS_TLAST, input, 1: marks the last beat of a batch.
REQ-009 Port S_AXIS_TVALID, input, 1: upstream beat valid.
REQ-010 Port S_AXIS_TREADY, output, 1: block can accept a beat.
REQ-011 Port q_data, output, N*CHAR_LEN: one sample; char j occupies bits [j*CHAR_LEN +: CHAR_LEN], char 0 at the LSBs.
REQ-012 Port q_valid, output, 1: q_data holds a valid sample.
REQ-013 Port q_ready, input, 1: downstream (embedding stage) accepts the sample.
REQ-014 Port q_last, output, 1: current sample is the last of the batch.
REQ-015 Port len_err, output, 1: sticky flag, batch length mismatch.

Function
REQ-016 The FSM SHALL have exactly three states: RECV, DRAIN, OUT.
REQ-017 In RECV, S_AXIS_TREADY = 1, q_valid = 0, and each accepted beat (TVALID & TREADY) SHALL write mem[wr_cnt] and increment wr_cnt.
REQ-018 A beat accepted with TLAST=1 and wr_cnt == BATCH_SIZE*N-1 SHALL be stored, and the FSM SHALL enter OUT on the next edge with rd_idx=0.
REQ-019 A beat accepted with TLAST=1 and wr_cnt < BATCH_SIZE*N-1 SHALL set len_err, discard the batch, reset wr_cnt to 0, and stay in RECV.
REQ-020 A beat accepted with TLAST=0 and wr_cnt == BATCH_SIZE*N-1 SHALL be stored; the FSM SHALL then enter DRAIN.
REQ-021 In DRAIN, S_AXIS_TREADY = 1 and beats are discarded; the TLAST beat SHALL set len_err, reset wr_cnt, and return to RECV.
REQ-022 In OUT, S_AXIS_TREADY = 0, q_valid = 1, q_data = mem[rd_idx*N .. rd_idx*N+N-1], and q_last = (rd_idx == BATCH_SIZE-1).
REQ-023 q_valid SHALL first assert exactly one cycle after the TLAST beat is accepted.
REQ-024 In OUT, q_data SHALL be combinational from mem and rd_idx, and stable while q_valid & !q_ready.
REQ-025 In OUT, q_valid & q_ready SHALL increment rd_idx; on the last sample it SHALL instead clear rd_idx and wr_cnt and return to RECV.
REQ-026 S_AXIS_TREADY SHALL be 1 in the cycle after the last sample handshake.
REQ-027 clear=1 SHALL force RECV, wr_cnt=0, rd_idx=0 and len_err=0 next cycle, from any state; it has priority over all handshakes in the same cycle.
REQ-028 len_err SHALL remain 1 until clear or ARESET.
REQ-029 wr_cnt SHALL be $clog2(BATCH_SIZE*N) bits wide and rd_idx $clog2(BATCH_SIZE) bits wide (minimum 1 bit); neither counter wraps within a valid batch.
REQ-030 mem contents SHALL NOT be reset; mem is only written in RECV.

Reset
REQ-031 ARESET=1 at a rising edge SHALL produce the same result as clear (REQ-027), including mid-batch and mid-OUT.
REQ-032 Output values during/after reset SHALL be: S_AXIS_TREADY=1, q_valid=0, q_last=0, len_err=0; q_data is don't-care while q_valid=0.

Structure
REQ-033 State encodings IB_RECV, IB_DRAIN, IB_OUT SHALL be defined in consts_train.vh beside the existing M_S* codes; CHAR_LEN, N and BATCH_SIZE SHALL be reused from it, with no local redefinition.
REQ-034 The block SHALL be a single module with no sub-modules; mem is a register array of BATCH_SIZE*N entries of CHAR_LEN bits.

Verification
REQ-035 Scenario, nominal batch: stream BATCH_SIZE*N beats with data=k (k = beat index), continuous TVALID, TLAST on the final beat, q_ready=1 -> BATCH_SIZE samples, sample s char j = s*N+j, q_last only on sample BATCH_SIZE-1, len_err=0.
REQ-036 Scenario, downstream backpressure: q_ready low 5 cycles per sample -> q_data and q_valid stable while stalled; TREADY=0 throughout OUT.
REQ-037 Scenario, short batch: TLAST on beat 3 -> len_err=1, no q_valid; a following good batch is delivered correctly with len_err still 1.
REQ-038 Scenario, long batch: BATCH_SIZE*N+2 beats, TLAST on the last -> len_err=1, no q_valid, FSM back in RECV.
REQ-039 Scenario, clear mid-OUT after sample 0 -> next cycle q_valid=0, TREADY=1, len_err=0; a new batch is received from index 0.
REQ-040 Scenario, ARESET asserted mid-RECV at beat 5 -> wr_cnt=0; a complete fresh batch then delivers data=k correctly.
